// File: rtl/lp_piped_mult_arbiter.sv
// rtl/lp_piped_mult_arbiter.sv - round-robin, credit-limited sharing of one launch/arrive pipelined multiplier
// Optional LP_MULT_ARB_PERF_EN adds saturating launch/stall counters.
module lp_piped_mult_arbiter #(
   parameter int N_REQ     = 4,
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int MAX_OUTST = 4,
   localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int PW       = A_WIDTH + B_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*A_WIDTH-1:0] req_a,
   input  logic [N_REQ*B_WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]         req_ready,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [PW-1:0]            rsp_product,
   input  logic [N_REQ-1:0]         rsp_ready,
   output logic [A_WIDTH-1:0]       mult_a,
   output logic [B_WIDTH-1:0]       mult_b,
   output logic                     mult_launch,
   output logic [IDW-1:0]           mult_launch_id,
   output logic                     mult_accept_n,
   input  logic [PW-1:0]            mult_product,
   input  logic                     mult_arrive,
   input  logic [IDW-1:0]           mult_arrive_id,
   input  logic                     mult_pipe_full,
   input  logic                     mult_pipe_ovf,
   output logic                     busy,
`ifdef LP_MULT_ARB_PERF_EN
   output logic [31:0]              perf_launches,
   output logic [31:0]              perf_stalls,
`endif
   output logic                     err
);

   localparam int CW = 4;

   logic [CW-1:0]      r_outst [N_REQ];
   logic [IDW-1:0]     r_rr_ptr;
   logic [IDW-1:0]     r_rsp_id;
   logic               r_rsp_full;
   logic [PW-1:0]      r_rsp_product;
   logic               r_err;

   logic [N_REQ-1:0]   w_elig;
   logic [N_REQ-1:0]   w_grant;
   logic [N_REQ-1:0]   w_rsp_valid;
   logic [N_REQ-1:0]   w_consume;
   logic [IDW-1:0]     w_grant_idx;
   logic               w_grant_any;
   logic [A_WIDTH-1:0] w_mult_a;
   logic [B_WIDTH-1:0] w_mult_b;
   logic               w_rsp_rdy_sel;
   logic               w_accept_n;
   logic               w_drain;
   logic               w_load;
   logic               w_arrive_bad;
   logic               w_any_outst;

   // A held response with an id outside the requester range has no owner and is simply dropped.
   always_comb begin
      w_rsp_rdy_sel = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_rsp_id == IDW'(i)) w_rsp_rdy_sel = rsp_ready[i];
      end
   end

   assign w_accept_n = r_rsp_full & ~w_rsp_rdy_sel;
   assign w_drain    = r_rsp_full & w_rsp_rdy_sel;
   assign w_load     = mult_arrive & ~w_accept_n;

   always_comb begin
      w_any_outst = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         w_elig[i]      = rst_n & enable & req_valid[i] & (r_outst[i] < CW'(MAX_OUTST))
                          & ~(mult_pipe_full & w_accept_n);
         w_rsp_valid[i] = r_rsp_full & (r_rsp_id == IDW'(i));
         w_consume[i]   = w_rsp_valid[i] & rsp_ready[i];
         w_any_outst    = w_any_outst | (r_outst[i] != '0);
      end
   end

   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_grant_any = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_grant_any && w_elig[(int'(r_rr_ptr) + k) % N_REQ]) begin
            w_grant_any = 1'b1;
            w_grant_idx = IDW'((int'(r_rr_ptr) + k) % N_REQ);
            w_grant[(int'(r_rr_ptr) + k) % N_REQ] = 1'b1;
         end
      end
   end

   always_comb begin
      w_mult_a = '0;
      w_mult_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_mult_a = req_a[i*A_WIDTH +: A_WIDTH];
            w_mult_b = req_b[i*B_WIDTH +: B_WIDTH];
         end
      end
   end

   // An id that matches no requester falls through as bad.
   always_comb begin
      w_arrive_bad = mult_arrive;
      for (int i = 0; i < N_REQ; i++) begin
         if (mult_arrive_id == IDW'(i)) w_arrive_bad = mult_arrive & (r_outst[i] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr      <= IDW'(N_REQ - 1);
         r_rsp_full    <= 1'b0;
         r_rsp_id      <= '0;
         r_rsp_product <= '0;
         r_err         <= 1'b0;
         for (int i = 0; i < N_REQ; i++) r_outst[i] <= '0;
      end else begin
         if (w_grant_any) r_rr_ptr <= w_grant_idx;
         for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i] && !w_consume[i])
               r_outst[i] <= r_outst[i] + CW'(1);
            else if (!w_grant[i] && w_consume[i] && r_outst[i] != '0)
               r_outst[i] <= r_outst[i] - CW'(1);
         end
         if (w_load) begin
            r_rsp_full    <= 1'b1;
            r_rsp_id      <= mult_arrive_id;
            r_rsp_product <= mult_product;
         end else if (w_drain) begin
            r_rsp_full    <= 1'b0;
         end
         if (mult_pipe_ovf || w_arrive_bad) r_err <= 1'b1;
      end
   end

`ifdef LP_MULT_ARB_PERF_EN
   logic [31:0] r_perf_launches;
   logic [31:0] r_perf_stalls;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_launches <= '0;
         r_perf_stalls   <= '0;
      end else begin
         if (w_grant_any && r_perf_launches != '1) r_perf_launches <= r_perf_launches + 32'd1;
         if (mult_arrive && w_accept_n && r_perf_stalls != '1) r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign perf_launches = r_perf_launches;
   assign perf_stalls   = r_perf_stalls;
`endif

   assign req_ready      = w_grant;
   assign mult_launch    = w_grant_any;
   assign mult_launch_id = w_grant_idx;
   assign mult_a         = w_mult_a;
   assign mult_b         = w_mult_b;
   assign mult_accept_n  = w_accept_n;
   assign rsp_valid      = w_rsp_valid;
   assign rsp_product    = r_rsp_product;
   assign busy           = r_rsp_full | w_any_outst;
   assign err            = r_err;

endmodule

// File: tb/tb_lp_piped_mult_arbiter.sv
// tb/tb_lp_piped_mult_arbiter.sv - directed bench for lp_piped_mult_arbiter with a latency-3 multiplier model
module tb_lp_piped_mult_arbiter;

   localparam int L   = 3;
   localparam int CAP = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_product;
   logic [3:0]  rsp_ready;
   logic [7:0]  mult_a;
   logic [7:0]  mult_b;
   logic        mult_launch;
   logic [1:0]  mult_launch_id;
   logic        mult_accept_n;
   logic [15:0] mult_product;
   logic        mult_arrive;
   logic [1:0]  mult_arrive_id;
   logic        mult_pipe_full;
   logic        mult_pipe_ovf;
   logic        busy;
   logic        err;
`ifdef LP_MULT_ARB_PERF_EN
   logic [31:0] perf_launches;
   logic [31:0] perf_stalls;
`endif

   // multiplier override controls
   logic        f_en, f_arrive, f_ovf;
   logic [1:0]  f_id;
   logic [15:0] f_prod;

   int n_vec = 0;
   int n_err = 0;

   lp_piped_mult_arbiter #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .MAX_OUTST(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_ready(rsp_ready),
      .mult_a(mult_a), .mult_b(mult_b), .mult_launch(mult_launch), .mult_launch_id(mult_launch_id),
      .mult_accept_n(mult_accept_n), .mult_product(mult_product), .mult_arrive(mult_arrive),
      .mult_arrive_id(mult_arrive_id), .mult_pipe_full(mult_pipe_full), .mult_pipe_ovf(mult_pipe_ovf),
      .busy(busy),
`ifdef LP_MULT_ARB_PERF_EN
      .perf_launches(perf_launches), .perf_stalls(perf_stalls),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   // In-order multiplier: each launch becomes available L cycles later, held while accept_n is high.
   int          cyc = 0;
   logic [15:0] m_prod [8];
   logic [1:0]  m_id   [8];
   int          m_due  [8];
   int          m_head = 0;
   int          m_cnt  = 0;
   logic        m_arr, m_pop;

   always_comb begin
      m_arr          = (m_cnt > 0) && (m_due[m_head] <= cyc);
      mult_arrive    = f_en ? f_arrive : m_arr;
      mult_arrive_id = f_en ? f_id     : m_id[m_head];
      mult_product   = f_en ? f_prod   : m_prod[m_head];
      mult_pipe_full = (m_cnt >= CAP);
      mult_pipe_ovf  = f_ovf;
      m_pop          = !f_en && m_arr && !mult_accept_n;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_head <= 0;
         m_cnt  <= 0;
      end else begin
         if (mult_launch) begin
            m_prod[(m_head + m_cnt) % 8] <= {8'd0, mult_a} * {8'd0, mult_b};
            m_id[(m_head + m_cnt) % 8]   <= mult_launch_id;
            m_due[(m_head + m_cnt) % 8]  <= cyc + L;
         end
         if (m_pop) m_head <= (m_head + 1) % 8;
         m_cnt <= m_cnt + (mult_launch ? 1 : 0) - (m_pop ? 1 : 0);
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; enable = 1'b0; req_valid = '0; rsp_ready = '0;
      req_a = '0; req_b = '0;
      f_en = 1'b0; f_arrive = 1'b0; f_ovf = 1'b0; f_id = '0; f_prod = '0;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      do_reset;
      req_valid = 4'hF; enable = 1'b1; rsp_ready = 4'hF;
      next_cycle;
      #1;
      n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_vec++; if (mult_launch !== 1'b0) begin n_err++; $display("FAIL reset_launch: got %b expected 0", mult_launch); end
      n_vec++; if (rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      n_vec++; if (rsp_product !== 16'h0) begin n_err++; $display("FAIL reset_rsp_product: got %h expected 0000", rsp_product); end
      n_vec++; if (mult_accept_n !== 1'b0) begin n_err++; $display("FAIL reset_accept_n: got %b expected 0", mult_accept_n); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
      rst_n = 1'b1; enable = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL enable_off_ready: got %b expected 0000", req_ready); end
      n_vec++; if (mult_launch !== 1'b0) begin n_err++; $display("FAIL enable_off_launch: got %b expected 0", mult_launch); end
      req_valid = '0;
   endtask

   task automatic test_round_robin;
      logic [3:0]  e;
      logic [15:0] prods [4];
      prods = '{16'd35, 16'd12, 16'd54, 16'd22};
      do_reset;
      req_a = {8'd2, 8'd6, 8'd3, 8'd5};
      req_b = {8'd11, 8'd9, 8'd4, 8'd7};
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'hF;
      for (int c = 0; c <= 8; c++) begin
         req_valid = (c < 4) ? 4'hF : 4'h0;
         #1;
         e = (c < 4) ? (4'b0001 << c) : 4'b0000;
         n_vec++; if (req_ready !== e) begin n_err++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, e); end
         e = (c >= 4 && c < 8) ? (4'b0001 << (c - 4)) : 4'b0000;
         n_vec++; if (rsp_valid !== e) begin n_err++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", c, rsp_valid, e); end
         if (c >= 4 && c < 8) begin
            n_vec++; if (rsp_product !== prods[c-4]) begin n_err++; $display("FAIL rr_product c%0d: got %0d expected %0d", c, rsp_product, prods[c-4]); end
         end
         if (c == 0) begin
            n_vec++; if ({mult_a, mult_b} !== {8'd5, 8'd7}) begin n_err++; $display("FAIL rr_operands: got %0d*%0d expected 5*7", mult_a, mult_b); end
         end
         if (c == 8) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_busy_idle: got %b expected 0", busy); end
            n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rr_err: got %b expected 0", err); end
         end
         next_cycle;
      end
   endtask

   task automatic test_credit_limit;
      int grants;
      logic [3:0] e;
      grants = 0;
      do_reset;
      req_a[23:16] = 8'd3; req_b[23:16] = 8'd3;
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'h0; req_valid = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         #1;
         e = (c < 4) ? 4'b0100 : 4'b0000;
         if (req_ready == 4'b0100) grants++;
         n_vec++; if (req_ready !== e) begin n_err++; $display("FAIL credit_grant c%0d: got %b expected %b", c, req_ready, e); end
         next_cycle;
      end
      n_vec++; if (grants !== 4) begin n_err++; $display("FAIL credit_total: got %0d expected 4", grants); end
      rsp_ready = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL credit_drain_cycle: got %b expected 0000", req_ready); end
      n_vec++; if (rsp_product !== 16'd9) begin n_err++; $display("FAIL credit_product: got %0d expected 9", rsp_product); end
      next_cycle;
      rsp_ready = 4'b0000;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL credit_regrant: got %b expected 0100", req_ready); end
      next_cycle;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL credit_refull: got %b expected 0000", req_ready); end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp_p;
      do_reset;
      req_b[15:8] = 8'd10;
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'h0;
      for (int c = 0; c < 4; c++) begin
         req_valid = 4'b0010;
         req_a[15:8] = 8'(c + 1);
         #1;
         n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant c%0d: got %b expected 0010", c, req_ready); end
         next_cycle;
      end
      req_valid = 4'b0000;
      #1;
      n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_held_valid: got %b expected 0010", rsp_valid); end
      n_vec++; if (mult_accept_n !== 1'b1) begin n_err++; $display("FAIL bp_accept_n: got %b expected 1", mult_accept_n); end
      next_cycle;
      req_valid = 4'b0001;
      #1;
      n_vec++; if (mult_pipe_full !== 1'b1) begin n_err++; $display("FAIL bp_model_full: got %b expected 1", mult_pipe_full); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_full_block: got %b expected 0000", req_ready); end
      next_cycle;
      req_valid = 4'b0000; rsp_ready = 4'hF;
`ifdef LP_MULT_ARB_PERF_EN
      #1;
      n_vec++; if (perf_stalls !== 32'd2) begin n_err++; $display("FAIL perf_stalls: got %0d expected 2", perf_stalls); end
      n_vec++; if (perf_launches !== 32'd4) begin n_err++; $display("FAIL perf_launches_bp: got %0d expected 4", perf_launches); end
      #1;
`else
      #2;
`endif
      for (int k = 0; k < 4; k++) begin
         exp_p = 16'(10 * (k + 1));
         n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_order_valid k%0d: got %b expected 0010", k, rsp_valid); end
         n_vec++; if (rsp_product !== exp_p) begin n_err++; $display("FAIL bp_order_product k%0d: got %0d expected %0d", k, rsp_product, exp_p); end
         next_cycle;
         #1;
      end
      n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL bp_empty: got %b expected 0000", rsp_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b expected 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bp_err: got %b expected 0", err); end
   endtask

   task automatic test_same_cycle;
      do_reset;
      req_a[15:8] = 8'd2; req_b[15:8] = 8'd2;
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'hF;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c == 0 || c == 4) ? 4'b0010 : 4'b0000;
         if (c == 4) begin req_a[15:8] = 8'd3; req_b[15:8] = 8'd3; end
         #1;
         if (c == 0 || c == 4) begin
            n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL same_grant c%0d: got %b expected 0010", c, req_ready); end
         end
         if (c == 4) begin
            n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL same_consume: got %b expected 0010", rsp_valid); end
            n_vec++; if (rsp_product !== 16'd4) begin n_err++; $display("FAIL same_product1: got %0d expected 4", rsp_product); end
         end
         if (c == 6) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL same_busy_inflight: got %b expected 1", busy); end
         end
         if (c == 8) begin
            n_vec++; if (rsp_valid !== 4'b0010 || rsp_product !== 16'd9) begin n_err++; $display("FAIL same_second: got %b/%0d expected 0010/9", rsp_valid, rsp_product); end
         end
         if (c == 9) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_busy_done: got %b expected 0", busy); end
            n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL same_err: got %b expected 0", err); end
         end
         next_cycle;
      end
   endtask

   task automatic test_err;
      do_reset;
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'hF;
      f_en = 1'b1; f_arrive = 1'b1; f_id = 2'd3; f_prod = 16'h00AA;
      #1;
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_before: got %b expected 0", err); end
      next_cycle;
      f_en = 1'b0; f_arrive = 1'b0;
      #1;
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", err); end
      repeat (5) next_cycle;
      #1;
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_busy: got %b expected 0", busy); end
      do_reset;
      rst_n = 1'b1;
      #1;
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b expected 0", err); end
      f_ovf = 1'b1;
      next_cycle;
      f_ovf = 1'b0;
      #1;
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_ovf: got %b expected 1", err); end
   endtask

   task automatic test_reset_midstream;
      do_reset;
      req_a = {8'd2, 8'd6, 8'd3, 8'd5};
      req_b = {8'd11, 8'd9, 8'd4, 8'd7};
      rst_n = 1'b1; enable = 1'b1; rsp_ready = 4'hF; req_valid = 4'hF;
      repeat (4) next_cycle;
      #1;
      n_vec++; if (rsp_valid !== 4'b0001 || rsp_product !== 16'd35) begin n_err++; $display("FAIL mid_pre_rsp: got %b/%0d expected 0001/35", rsp_valid, rsp_product); end
`ifdef LP_MULT_ARB_PERF_EN
      n_vec++; if (perf_launches !== 32'd4) begin n_err++; $display("FAIL mid_perf_pre: got %0d expected 4", perf_launches); end
`endif
      rst_n = 1'b0;
      next_cycle;
      #1;
      n_vec++; if (req_ready !== 4'h0 || mult_launch !== 1'b0) begin n_err++; $display("FAIL mid_grant: got %b/%b expected 0000/0", req_ready, mult_launch); end
      n_vec++; if (rsp_valid !== 4'h0 || rsp_product !== 16'h0) begin n_err++; $display("FAIL mid_rsp: got %b/%h expected 0000/0000", rsp_valid, rsp_product); end
      n_vec++; if (busy !== 1'b0 || err !== 1'b0 || mult_accept_n !== 1'b0) begin n_err++; $display("FAIL mid_status: got busy=%b err=%b acc_n=%b expected 0/0/0", busy, err, mult_accept_n); end
`ifdef LP_MULT_ARB_PERF_EN
      n_vec++; if (perf_launches !== 32'd0 || perf_stalls !== 32'd0) begin n_err++; $display("FAIL mid_perf_clr: got %0d/%0d expected 0/0", perf_launches, perf_stalls); end
`endif
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_credit_limit;
      test_backpressure;
      test_same_cycle;
      test_err;
      test_reset_midstream;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
